image_upscale: RTL
==================

Name: image_upscale

Overview:
- Streaming pixel upscaler; the enlarging counterpart to the image-size converter's decimating path.
- Input: i_image_width x i_image_depth 8-bit pixels, raster order.
- Output: (width*width_scale) x (depth*depth_scale) pixels. Each pixel is repeated width_scale times horizontally; each line is repeated depth_scale times vertically.
- Sits between the AXI-Stream source and the display/DMA sink; lines for vertical repetition come from an internal line buffer.

Parameters:
- DATA_WIDTH, 8, pixel width in bits
- MAX_WIDTH, 1024, line buffer depth; largest supported i_image_width

Ports:
- axi_aclk  input  1  clock; all logic on rising edge
- axi_reset  input  1  synchronous, active-high reset
- i_image_width  input  32  input pixels per line
- i_image_depth  input  32  input lines per frame
- i_width_scale  input  32  horizontal repeat factor; bits [7:0] used
- i_depth_scale  input  32  vertical repeat factor; bits [7:0] used
- i_image_data  input  DATA_WIDTH  input pixel
- i_image_data_valid  input  1  input pixel valid
- o_image_data_ready  output  1  block accepts input this cycle
- o_image_data  output  DATA_WIDTH  output pixel (registered)
- o_image_data_valid  output  1  output pixel valid (registered)
- i_image_data_ready  input  1  downstream ready
- o_frame_done  output  1  one-cycle pulse after the last output beat of a frame
- o_config_err  output  1  latched configuration is illegal

Behaviour:
- One clock domain. Synchronous active-high reset.
- Reset values: o_image_data_valid=0, o_image_data=0, o_image_data_ready=0, o_frame_done=0, o_config_err=0; state=FILL; all counters 0.
- Handshakes:
  - Input transfer: i_image_data_valid & o_image_data_ready.
  - Output transfer: o_image_data_valid & i_image_data_ready.
  - slot_free = !o_image_data_valid | i_image_data_ready.
  - Once asserted, o_image_data and o_image_data_valid hold until the beat is transferred.
- Config latch: width, depth, ws, ds are latched on the first cycle after reset and on the cycle after o_frame_done. Scale value 0 is treated as 1.
- Config error: o_config_err=1 if latched width==0, width>MAX_WIDTH, or depth==0. While set, o_image_data_ready=0 and no output is produced. It re-evaluates at the next latch point.
- FILL state (first copy of each input line):
  - o_image_data_ready = slot_free & (rep_cnt==0).
  - On accept: o_image_data<=pixel; o_image_data_valid<=1; linebuf[pix_cnt]<=pixel; rep_cnt<=ws-1; pix_cnt++.
  - While rep_cnt!=0 and slot_free: re-present the same pixel as a new beat; rep_cnt--.
  - Latency: input accept to first output beat = 1 cycle.
  - Throughput: 1 output beat/cycle; 1 input every ws cycles.
  - On the final repeat of pixel width-1: if ds>1 go to REPLAY with row_rep=1; else advance src_row and stay in FILL.
- REPLAY state:
  - o_image_data_ready=0.
  - Read linebuf[0..width-1] (synchronous read, 1-cycle latency; address issued ahead). Emit each pixel ws times.
  - No bubbles within a row when i_image_data_ready is held high. At most 1 idle cycle at each row start.
  - After row_rep==ds-1 completes: src_row++ and go to FILL.
- Frame end:
  - After the final beat of line (src_row==depth-1, row_rep==ds-1) is transferred: o_frame_done=1 for one cycle.
  - Counters clear, config is re-latched, state=FILL.
- Counters and wrap:
  - pix_cnt: 0..width-1.
  - rep_cnt: 0..ws-1.
  - row_rep: 0..ds-1.
  - src_row: 0..depth-1.
  - All counters wrap to 0 at their terminal value; no overflow beyond the latched dimensions.
- Stalls: i_image_data_ready low freezes all counters and the FSM. i_image_data_valid low in FILL only stalls input; already-pending repeats still drain.
- Reset mid-operation: takes effect the next edge. Any in-flight beat is dropped, outputs return to reset values, line buffer contents are don't-care.
- Config changes mid-frame are ignored until the next latch point.

Test Plan:
- Basic upscale: width=4, depth=2, ws=2, ds=3; rows A0..A3, B0..B3; sink always ready -> 6 rows of 8 beats: 3x "A0 A0 A1 A1 A2 A2 A3 A3" then 3x the B pattern; 48 beats total; o_frame_done pulses once, 1 cycle after the 48th beat.
- Pass-through: ws=1, ds=1, width=16, depth=4, source always valid -> output equals input delayed 1 cycle; o_image_data_ready continuously high; 64 beats; no REPLAY entry.
- Backpressure: same config as the basic upscale; i_image_data_ready randomly toggled 50%; i_image_data_valid random -> output sequence identical to the basic upscale; o_image_data stable whenever valid is high and ready is low.
- Scale-zero and limits: ws=0, ds=0 -> behaves as 1/1. width=MAX_WIDTH=1024, ws=1, ds=2 -> each line output twice, 2048 beats per input line, at most 1 idle cycle between rows.
- Config error: width=1025 -> o_config_err=1, o_image_data_ready=0, no output. Then width=8 with reset pulse -> err clears and normal operation resumes.
- Reset mid-REPLAY: assert axi_axi reset during row_rep=1 of the basic upscale -> next cycle o_image_data_valid=0 and o_image_data_ready=0; after release, a fresh frame is processed from pixel 0 and 48 correct beats are produced.

Source files
------------

// File: rtl/image_upscale.sv
// image_upscale: streaming pixel/line replicator; a line buffer supplies the vertical repeats.
module image_upscale #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 1024
) (
  input  logic                  axi_aclk,
  input  logic                  axi_reset,
  input  logic [31:0]           i_image_width,
  input  logic [31:0]           i_image_depth,
  input  logic [31:0]           i_width_scale,
  input  logic [31:0]           i_depth_scale,
  input  logic [DATA_WIDTH-1:0] i_image_data,
  input  logic                  i_image_data_valid,
  output logic                  o_image_data_ready,
  output logic [DATA_WIDTH-1:0] o_image_data,
  output logic                  o_image_data_valid,
  input  logic                  i_image_data_ready,
  output logic                  o_frame_done,
  output logic                  o_config_err
);
  localparam int AW = $clog2(MAX_WIDTH);
  localparam logic [1:0] FILL = 2'd0, REPLAY = 2'd1, DRAIN = 2'd2;
  logic [1:0] st_q, st_d;
  logic [AW-1:0] pix_q, pix_d, rd_addr;
  logic [7:0] rep_q, rep_d, rr_q, rr_d, ws_q, ds_q;
  logic [31:0] row_q, row_d, width_q, depth_q;
  logic pv_q, pv_d, init_q, done_q, err_q, valid_q;
  logic [DATA_WIDTH-1:0] data_q, rdata_q, beat;
  logic [DATA_WIDTH-1:0] mem [MAX_WIDTH];
  logic latch, slot_free, run, accept, emit, fin_rep, fin_pix, last_rr, last_row, rd_en;
  logic unused_bits;
  assign unused_bits = ^{i_width_scale[31:8], i_depth_scale[31:8]};
  assign latch = init_q | done_q;
  assign slot_free = !valid_q | i_image_data_ready;
  assign run = !latch & !err_q;
  assign o_image_data_ready = run & (st_q == FILL) & slot_free & (rep_q == 8'd0);
  assign accept = i_image_data_valid & o_image_data_ready;
  assign emit = run & slot_free & ((st_q == FILL) ? (accept | (rep_q != 8'd0)) : ((st_q == REPLAY) & pv_q));
  assign fin_rep = emit & (rep_q == ws_q - 8'd1);
  assign fin_pix = fin_rep & (32'(pix_q) == width_q - 32'd1);
  assign last_rr = rr_q == ds_q - 8'd1;
  assign last_row = row_q == depth_q - 32'd1;
  assign beat = (st_q == REPLAY) ? rdata_q : accept ? i_image_data : data_q;
  // pv_q marks rdata_q as holding the current replay pixel; the next one is fetched on its final repeat
  assign rd_en = (st_q == REPLAY) & (!pv_q | (fin_rep & !fin_pix));
  assign rd_addr = pv_q ? pix_q + AW'(1) : pix_q;
  assign o_image_data = data_q;
  assign o_image_data_valid = valid_q;
  assign o_frame_done = done_q;
  assign o_config_err = err_q;
  always_comb begin
    st_d = st_q;
    rr_d = rr_q;
    row_d = row_q;
    rep_d = fin_rep ? 8'd0 : emit ? rep_q + 8'd1 : rep_q;
    pix_d = fin_pix ? '0 : fin_rep ? pix_q + AW'(1) : pix_q;
    pv_d = rd_en | pv_q;
    if (fin_pix) begin
      pv_d = 1'b0;
      rr_d = last_rr ? 8'd0 : rr_q + 8'd1;
      row_d = !last_rr ? row_q : last_row ? 32'd0 : row_q + 32'd1;
      st_d = !last_rr ? REPLAY : last_row ? DRAIN : FILL;
    end else if (st_q == DRAIN && slot_free) begin
      st_d = FILL;
    end
  end
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      st_q <= FILL;
      pix_q <= '0;
      rep_q <= 8'd0;
      rr_q <= 8'd0;
      row_q <= 32'd0;
      pv_q <= 1'b0;
      init_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
      width_q <= 32'd0;
      depth_q <= 32'd0;
      ws_q <= 8'd1;
      ds_q <= 8'd1;
    end else begin
      st_q <= st_d;
      pix_q <= pix_d;
      rep_q <= rep_d;
      rr_q <= rr_d;
      row_q <= row_d;
      pv_q <= pv_d;
      init_q <= 1'b0;
      done_q <= (st_q == DRAIN) && slot_free;
      if (latch) begin
        width_q <= i_image_width;
        depth_q <= i_image_depth;
        ws_q <= (i_width_scale[7:0] == 8'd0) ? 8'd1 : i_width_scale[7:0];
        ds_q <= (i_depth_scale[7:0] == 8'd0) ? 8'd1 : i_depth_scale[7:0];
        err_q <= (i_image_width == 32'd0) || (i_image_width > 32'(MAX_WIDTH)) || (i_image_depth == 32'd0);
      end
      if (emit) begin
        data_q <= beat;
        valid_q <= 1'b1;
      end else if (i_image_data_ready) begin
        valid_q <= 1'b0;
      end
    end
  end
  always_ff @(posedge axi_aclk) begin
    if (accept) mem[pix_q] <= i_image_data;
    if (rd_en) rdata_q <= mem[rd_addr];
  end
endmodule
